// File: rtl/qm_execute.sv
// qm_execute: execute stage of the qm MIPS pipeline.
// ALU, registered execute/memory interface and, when QM_EXEC_MULDIV_EN is
// defined, HI/LO plus an iterative (one bit per cycle) multiply/divide unit.
// Without QM_EXEC_MULDIV_EN the MD codes are NOPs and o_Busy/o_Stall are 0.
module qm_execute #(
  parameter int unsigned MD_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_Valid,
  input  logic [31:0] di_RSVal,
  input  logic [31:0] di_RTVal,
  input  logic [31:0] di_Imm,
  input  logic [4:0]  di_RT,
  input  logic [4:0]  di_RD,
  input  logic [3:0]  ci_ALUControl,
  input  logic        ci_ALUSource,
  input  logic        ci_RegDest,
  input  logic        ci_RegWrite,
  input  logic        ci_RegWSource,
  input  logic        ci_MemWrite,
  output logic        o_Stall,
  output logic        o_Busy,
  output logic        o_Valid,
  output logic [31:0] do_ALUResult,
  output logic [31:0] do_WriteData,
  output logic [4:0]  do_WriteReg,
  output logic        co_RegWrite,
  output logic        co_RegWSource,
  output logic        co_MemWrite
);

  logic [31:0] alu_b;
  logic [4:0]  shamt;
  logic        md_code;
  logic        md_start_code;
  logic        accept;
  logic        busy;
  logic [31:0] hi_val;
  logic [31:0] lo_val;
  logic [31:0] alu_res;

  assign alu_b         = ci_ALUSource ? di_Imm : di_RTVal;
  assign shamt         = di_Imm[10:6];
  assign md_code       = (ci_ALUControl >= 4'd11);
  assign md_start_code = md_code && (ci_ALUControl != 4'd15);
  assign accept        = i_Valid && !o_Stall;
  assign o_Busy        = busy;

`ifdef QM_EXEC_MULDIV_EN
  typedef enum logic [1:0] {MD_IDLE, MD_MUL, MD_DIV} md_state_e;
  localparam int unsigned CW = $clog2(MD_CYCLES + 1);

  md_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        neg_q, neg_d;
  logic        rneg_q, rneg_d;
  logic        dz_q, dz_d;
  logic        signed_op;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic [63:0] prod;

  // acc holds {partial product, multiplier} for MUL and {remainder, quotient}
  // for DIV; magnitudes are processed and the sign is applied on the last step.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    dz_d      = dz_q;
    prod      = '0;
    signed_op = (ci_ALUControl == 4'd11) || (ci_ALUControl == 4'd13);
    a_mag     = (signed_op && di_RSVal[31]) ? -di_RSVal : di_RSVal;
    b_mag     = (signed_op && di_RTVal[31]) ? -di_RTVal : di_RTVal;
    mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};
    div_shift = {acc_q[63:32], acc_q[31]};
    div_diff  = div_shift - {1'b0, opnd_q};
    case (state_q)
      MD_IDLE: begin
        if (accept && md_start_code) begin
          state_d = (ci_ALUControl <= 4'd12) ? MD_MUL : MD_DIV;
          cnt_d   = CW'(MD_CYCLES);
          opnd_d  = b_mag;
          acc_d   = {32'd0, a_mag};
          neg_d   = signed_op && (di_RSVal[31] ^ di_RTVal[31]);
          rneg_d  = signed_op && di_RSVal[31];
          dz_d    = (di_RTVal == '0);
        end
      end
      MD_MUL: begin
        if (acc_q[0]) acc_d = {mul_sum, acc_q[31:1]};
        else          acc_d = {1'b0, acc_q[63:1]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          prod    = neg_q ? -acc_d : acc_d;
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
          state_d = MD_IDLE;
        end
      end
      MD_DIV: begin
        // Divisor zero never borrows, leaving quotient all ones and |A| as
        // remainder; re-signing the remainder with sign(A) restores di_RSVal.
        if (!div_diff[32]) acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
        else               acc_d = {div_shift[31:0], acc_q[30:0], 1'b0};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          hi_d    = rneg_q ? -acc_d[63:32] : acc_d[63:32];
          lo_d    = dz_q ? '1 : (neg_q ? -acc_d[31:0] : acc_d[31:0]);
          state_d = MD_IDLE;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // Multiply/divide state, operands and HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
    end
  end

  assign busy    = (state_q != MD_IDLE);
  assign o_Stall = i_Valid && busy && md_code;
  assign hi_val  = hi_q;
  assign lo_val  = lo_q;
`else
  logic unused_md_cfg;
  assign unused_md_cfg = (MD_CYCLES != 0);
  assign busy    = 1'b0;
  assign o_Stall = 1'b0;
  assign hi_val  = '0;
  assign lo_val  = '0;
`endif

  // ALU result for the slot currently presented.
  always_comb begin
    alu_res = '0;
    case (ci_ALUControl)
      4'd0:  alu_res = di_RSVal & alu_b;
      4'd1:  alu_res = di_RSVal | alu_b;
      4'd2:  alu_res = di_RSVal + alu_b;
      4'd3:  alu_res = di_RSVal ^ alu_b;
      4'd4:  alu_res = ~(di_RSVal | alu_b);
      4'd5:  alu_res = alu_b << shamt;
      4'd6:  alu_res = di_RSVal - alu_b;
      4'd7:  alu_res = {31'd0, ($signed(di_RSVal) < $signed(alu_b))};
      4'd8:  alu_res = {31'd0, (di_RSVal < alu_b)};
      4'd9:  alu_res = alu_b >> shamt;
      4'd10: alu_res = 32'($signed(alu_b) >>> shamt);
      4'd15: alu_res = di_Imm[1] ? lo_val : hi_val;
      default: alu_res = '0;
    endcase
  end

  logic        valid_q, valid_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [31:0] write_data_q, write_data_d;
  logic [4:0]  write_reg_q, write_reg_d;
  logic        reg_write_q, reg_write_d;
  logic        reg_wsource_q, reg_wsource_d;
  logic        mem_write_q, mem_write_d;

  // Next execute/memory slot: accepted instruction or a bubble holding data.
  always_comb begin
    valid_d       = 1'b0;
    reg_write_d   = 1'b0;
    mem_write_d   = 1'b0;
    alu_result_d  = alu_result_q;
    write_data_d  = write_data_q;
    write_reg_d   = write_reg_q;
    reg_wsource_d = reg_wsource_q;
    if (accept) begin
      valid_d       = 1'b1;
      reg_write_d   = ci_RegWrite && !md_start_code;
      mem_write_d   = ci_MemWrite;
      alu_result_d  = alu_res;
      write_data_d  = di_RTVal;
      write_reg_d   = ci_RegDest ? di_RD : di_RT;
      reg_wsource_d = ci_RegWSource;
    end
  end

  // Execute/memory pipeline register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q       <= 1'b0;
      alu_result_q  <= '0;
      write_data_q  <= '0;
      write_reg_q   <= '0;
      reg_write_q   <= 1'b0;
      reg_wsource_q <= 1'b0;
      mem_write_q   <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      alu_result_q  <= alu_result_d;
      write_data_q  <= write_data_d;
      write_reg_q   <= write_reg_d;
      reg_write_q   <= reg_write_d;
      reg_wsource_q <= reg_wsource_d;
      mem_write_q   <= mem_write_d;
    end
  end

  assign o_Valid       = valid_q;
  assign do_ALUResult  = alu_result_q;
  assign do_WriteData  = write_data_q;
  assign do_WriteReg   = write_reg_q;
  assign co_RegWrite   = reg_write_q;
  assign co_RegWSource = reg_wsource_q;
  assign co_MemWrite   = mem_write_q;

endmodule

// File: tb/tb_qm_execute.sv
// Self-checking bench for qm_execute: directed vectors, behavioural model
// compared every cycle, plus hand-computed literal expectations.
module tb_qm_execute;

`ifdef QM_EXEC_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_Valid = 1'b0;
  logic [31:0] di_RSVal = '0, di_RTVal = '0, di_Imm = '0;
  logic [4:0]  di_RT = '0, di_RD = '0;
  logic [3:0]  ci_ALUControl = '0;
  logic        ci_ALUSource = 1'b0, ci_RegDest = 1'b0, ci_RegWrite = 1'b0;
  logic        ci_RegWSource = 1'b0, ci_MemWrite = 1'b0;
  logic        o_Stall, o_Busy, o_Valid;
  logic [31:0] do_ALUResult, do_WriteData;
  logic [4:0]  do_WriteReg;
  logic        co_RegWrite, co_RegWSource, co_MemWrite;

  qm_execute #(.MD_CYCLES(32)) dut (
    .clk(clk), .reset(rst_n), .i_Valid(i_Valid),
    .di_RSVal(di_RSVal), .di_RTVal(di_RTVal), .di_Imm(di_Imm),
    .di_RT(di_RT), .di_RD(di_RD), .ci_ALUControl(ci_ALUControl),
    .ci_ALUSource(ci_ALUSource), .ci_RegDest(ci_RegDest),
    .ci_RegWrite(ci_RegWrite), .ci_RegWSource(ci_RegWSource),
    .ci_MemWrite(ci_MemWrite), .o_Stall(o_Stall), .o_Busy(o_Busy),
    .o_Valid(o_Valid), .do_ALUResult(do_ALUResult),
    .do_WriteData(do_WriteData), .do_WriteReg(do_WriteReg),
    .co_RegWrite(co_RegWrite), .co_RegWSource(co_RegWSource),
    .co_MemWrite(co_MemWrite)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int stall_cnt = 0;

  // ---------------- behavioural model ----------------
  int          busy_left;
  logic [31:0] m_hi, m_lo;
  logic [63:0] pend;
  logic        e_valid, e_rw, e_ws, e_mw;
  logic [31:0] e_res, e_wd;
  logic [4:0]  e_wr;
  logic [31:0] m_b;
  logic        m_stall, m_acc, m_start;

  function automatic logic [31:0] ref_alu(input logic [3:0] code,
      input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
      input logic [31:0] hi, input logic [31:0] lo);
    int sh;
    sh = int'(imm[10:6]);
    case (code)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a ^ b;
      4'd4:  return ~(a | b);
      4'd5:  return b << sh;
      4'd6:  return a - b;
      4'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8:  return (a < b) ? 32'd1 : 32'd0;
      4'd9:  return b >> sh;
      4'd10: return 32'($signed(b) >>> sh);
      4'd15: return MD_EN ? (imm[1] ? lo : hi) : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // {HI,LO} an MD op must leave behind.
  function automatic logic [63:0] ref_md(input logic [3:0] code,
      input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = $signed(a);
    ib = $signed(b);
    case (code)
      4'd11: return 64'(sa * sb);
      4'd12: return {32'd0, a} * {32'd0, b};
      4'd13: if (b == 0) return {a, 32'hFFFFFFFF};
             else return {32'(ia % ib), 32'(ia / ib)};
      4'd14: if (b == 0) return {a, 32'hFFFFFFFF};
             else return {a % b, a / b};
      default: return 64'd0;
    endcase
  endfunction

  always_comb begin
    m_b     = ci_ALUSource ? di_Imm : di_RTVal;
    m_stall = MD_EN && i_Valid && (busy_left != 0) && (ci_ALUControl >= 4'd11);
    m_acc   = i_Valid && !m_stall;
    m_start = MD_EN && m_acc && (ci_ALUControl >= 4'd11) && (ci_ALUControl <= 4'd14);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_left <= 0; m_hi <= '0; m_lo <= '0; pend <= '0;
      e_valid <= 1'b0; e_rw <= 1'b0; e_ws <= 1'b0; e_mw <= 1'b0;
      e_res <= '0; e_wd <= '0; e_wr <= '0;
    end else begin
      if (m_acc) begin
        e_valid <= 1'b1;
        e_res   <= ref_alu(ci_ALUControl, di_RSVal, m_b, di_Imm, m_hi, m_lo);
        e_wd    <= di_RTVal;
        e_wr    <= ci_RegDest ? di_RD : di_RT;
        e_rw    <= ci_RegWrite && !((ci_ALUControl >= 4'd11) && (ci_ALUControl <= 4'd14));
        e_ws    <= ci_RegWSource;
        e_mw    <= ci_MemWrite;
      end else begin
        e_valid <= 1'b0;
        e_rw    <= 1'b0;
        e_mw    <= 1'b0;
      end
      if (busy_left != 0) begin
        busy_left <= busy_left - 1;
        if (busy_left == 1) begin
          m_hi <= pend[63:32];
          m_lo <= pend[31:0];
        end
      end
      if (m_start) begin
        busy_left <= 32;
        pend      <= ref_md(ci_ALUControl, di_RSVal, di_RTVal);
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    check("o_Valid",       32'(o_Valid),       32'(e_valid));
    check("o_Busy",        32'(o_Busy),        32'(busy_left != 0));
    check("o_Stall",       32'(o_Stall),       32'(m_stall));
    check("do_ALUResult",  do_ALUResult,       e_res);
    check("do_WriteData",  do_WriteData,       e_wd);
    check("do_WriteReg",   32'(do_WriteReg),   32'(e_wr));
    check("co_RegWrite",   32'(co_RegWrite),   32'(e_rw));
    check("co_RegWSource", 32'(co_RegWSource), 32'(e_ws));
    check("co_MemWrite",   32'(co_MemWrite),   32'(e_mw));
    if (o_Stall) stall_cnt++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_Valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // Present one instruction and hold it until the model says it was taken.
  task automatic issue(input logic [3:0] code, input logic [31:0] rs,
      input logic [31:0] rt, input logic [31:0] imm, input logic src,
      input logic rdst, input logic [4:0] rtf, input logic [4:0] rdf,
      input logic rw, input logic ws, input logic mw);
    bit was_stall;
    int n;
    i_Valid = 1'b1; ci_ALUControl = code; di_RSVal = rs; di_RTVal = rt;
    di_Imm = imm; ci_ALUSource = src; ci_RegDest = rdst; di_RT = rtf;
    di_RD = rdf; ci_RegWrite = rw; ci_RegWSource = ws; ci_MemWrite = mw;
    n = 0;
    do begin
      was_stall = m_stall;
      step();
      n++;
    end while (was_stall && n < 200);
    if (was_stall) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: stalled %0d cycles, required under 200", n);
    end
  endtask

  task automatic mf(input bit lo);
    issue(4'd15, 32'd0, 32'd0, lo ? 32'h12 : 32'h10, 1'b0, 1'b1, 5'd0, 5'd9,
          1'b1, 1'b0, 1'b0);
  endtask

  localparam logic [3:0] C_MULT = 4'd11, C_MULTU = 4'd12, C_DIV = 4'd13, C_DIVU = 4'd14;

  initial begin
    int base;
    logic [31:0] ta, tb, ti;
    #100_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [31:0] ta, tb, ti;
    rst_n = 1'b0;
    #2;
    fork
      forever begin
        @(negedge clk);
        compare_cycle();
      end
    join_none
    step(); step();
    check("reset_valid",  32'(o_Valid), 32'd0);
    check("reset_result", do_ALUResult, 32'd0);
    check("reset_busy",   32'(o_Busy),  32'd0);
    rst_n = 1'b1;
    step();

    // ADD with immediate: 5 + (-3)
    issue(4'd2, 32'd5, 32'h1111, 32'hFFFFFFFD, 1'b1, 1'b0, 5'd7, 5'd3, 1'b1, 1'b0, 1'b0);
    check("add_result", do_ALUResult, 32'd2);
    check("add_wreg",   32'(do_WriteReg), 32'd7);
    check("add_valid",  32'(o_Valid), 32'd1);
    issue(4'd10, 32'd0, 32'h80000000, 32'h100, 1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
    check("sra_result", do_ALUResult, 32'hF8000000);
    issue(4'd7, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b1, 5'd1, 5'd4, 1'b1, 1'b0, 1'b0);
    check("slt_result", do_ALUResult, 32'd1);
    issue(4'd8, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b1, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0);
    check("sltu_result", do_ALUResult, 32'd0);

    // Sweep of the plain ALU codes, alternating operand source and controls
    ta = 32'hF0F01234; tb = 32'h0FF08001; ti = 32'h00000145;
    for (int c = 0; c <= 10; c++) begin
      issue(4'(c), ta, tb, ti, 1'(c % 2), 1'(c % 3 == 0), 5'(c + 1), 5'(c + 16),
            1'(c % 2 == 0), 1'(c % 4 == 1), 1'(c == 6));
      ta = {ta[30:0], ta[31]};
    end
    idle(2);

    // MULT -3*7 then MFLO presented while busy
    issue(C_MULT, 32'hFFFFFFFD, 32'd7, 32'd0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    base = stall_cnt;
    mf(1'b1);
    check("mult_stall_cycles", 32'(stall_cnt - base), MD_EN ? 32'd32 : 32'd0);
    check("mult_lo", do_ALUResult, MD_EN ? 32'hFFFFFFEB : 32'd0);
    mf(1'b0);
    check("mult_hi", do_ALUResult, MD_EN ? 32'hFFFFFFFF : 32'd0);

    // DIV -7/2
    issue(C_DIV, 32'hFFFFFFF9, 32'd2, 32'd0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    mf(1'b1);
    check("div_lo", do_ALUResult, MD_EN ? 32'hFFFFFFFD : 32'd0);
    mf(1'b0);
    check("div_hi", do_ALUResult, MD_EN ? 32'hFFFFFFFF : 32'd0);

    // DIVU 9/0
    issue(C_DIVU, 32'd9, 32'd0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    idle(3);
    mf(1'b1);
    check("divz_lo", do_ALUResult, MD_EN ? 32'hFFFFFFFF : 32'd0);
    mf(1'b0);
    check("divz_hi", do_ALUResult, MD_EN ? 32'd9 : 32'd0);

    // Signed DIV by zero with negative dividend: HI returns RS unchanged
    issue(C_DIV, 32'hFFFFFF00, 32'd0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    mf(1'b0);
    mf(1'b1);

    // Overlap: ADD during busy, MF stalls, second MULT stalls
    issue(C_MULTU, 32'h00010000, 32'h00030000, 32'd0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    base = stall_cnt;
    issue(4'd2, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 5'd3, 5'd11, 1'b1, 1'b0, 1'b1);
    check("overlap_add_result", do_ALUResult, 32'd3);
    check("overlap_add_nostall", 32'(stall_cnt - base), 32'd0);
    mf(1'b0);
    check("multu_hi", do_ALUResult, MD_EN ? 32'd3 : 32'd0);
    mf(1'b1);
    check("multu_lo", do_ALUResult, 32'd0);
    issue(C_MULT, 32'hFFFFFFFE, 32'hFFFFFFFB, 32'd0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    issue(4'd0, 32'hFF00FF00, 32'h0F0F0F0F, 32'd0, 1'b0, 1'b0, 5'd12, 5'd13, 1'b1, 1'b1, 1'b0);
    base = stall_cnt;
    issue(C_MULT, 32'd7, 32'd3, 32'd0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    check("second_mult_stall", 32'(stall_cnt - base), MD_EN ? 32'd31 : 32'd0);
    mf(1'b1);
    check("second_mult_lo", do_ALUResult, MD_EN ? 32'd21 : 32'd0);

    // Reset while DIV is at counter 10
    issue(C_DIV, 32'd100, 32'd7, 32'd0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    idle(22);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rst_mid_busy",  32'(o_Busy),  32'd0);
    check("rst_mid_valid", 32'(o_Valid), 32'd0);
    base = stall_cnt;
    mf(1'b0);
    check("rst_mid_hi", do_ALUResult, 32'd0);
    mf(1'b1);
    check("rst_mid_lo", do_ALUResult, 32'd0);
    check("rst_mid_nostall", 32'(stall_cnt - base), 32'd0);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
